// File: rtl/online_arith_pkg.sv
// Shared definitions for the online-arithmetic blocks: FSM states, digit
// legality bounds and the on-the-fly conversion result width.
package online_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01,
        ST_DONE = 2'b10
    } rtb_state_e;

    // One extra bit above ND*L carries the sign of the converted value.
    function automatic int otf_result_width(input int nd, input int l);
        return nd * l + 32'sd1;
    endfunction

    function automatic int digit_max(input int radix);
        return radix - 32'sd1;
    endfunction

    function automatic int digit_min(input int radix);
        return 32'sd1 - radix;
    endfunction

endpackage

// File: rtl/otf_digit_step.sv
// One step of MSD-first on-the-fly conversion: appends a signed digit to the
// Q / QM pair (QM == Q-1) using only shift-and-append selection.
module otf_digit_step #(
    parameter int RADIX_BITS = 2,
    parameter int L          = 1,
    parameter int W          = 10
) (
    input  logic [W-1:0]          q,
    input  logic [W-1:0]          qm,
    input  logic [RADIX_BITS-1:0] d,
    output logic [W-1:0]          q_next,
    output logic [W-1:0]          qm_next
);

    localparam logic [L-1:0] ONES = '1;

    logic [L-1:0] d_lo_s;
    logic [L-1:0] dm1_lo_s;

    // Low L bits of d equal RADIX+d for negative digits, so one slice serves both signs.
    assign d_lo_s   = d[L-1:0];
    assign dm1_lo_s = d_lo_s - L'(1);

    // Select the shift source (Q or QM) and the appended digit by the sign of d.
    always_comb begin
        q_next  = q << L;
        qm_next = qm << L;
        if (d == '0) begin
            q_next  = q << L;
            qm_next = (qm << L) | W'(ONES);
        end else if (d[RADIX_BITS-1]) begin
            q_next  = (qm << L) | W'(d_lo_s);
            qm_next = (qm << L) | W'(dm1_lo_s);
        end else begin
            q_next  = (q << L) | W'(d_lo_s);
            qm_next = (q << L) | W'(dm1_lo_s);
        end
    end

endmodule

// File: rtl/redundant_to_binary_converter.sv
// Serial MSD-first redundant-to-two's-complement converter, one digit per clock.
// Optional digit range checking is built when RTB_DIGIT_CHECK_EN is defined.
module redundant_to_binary_converter
    import online_arith_pkg::*;
#(
    parameter int NO_OF_DIGITS = 8,
    parameter int RADIX_BITS   = 2,
    parameter int RADIX        = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]    in_dout,
    input  logic [RADIX_BITS-1:0]                 in_cout,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [otf_result_width(NO_OF_DIGITS+1, $clog2(RADIX))-1:0] out_value,
    output logic                                  out_err
);

    localparam int L     = $clog2(RADIX);
    localparam int ND    = NO_OF_DIGITS + 1;
    localparam int W     = otf_result_width(ND, L);
    localparam int SR_W  = ND * RADIX_BITS;
    localparam int CNT_W = $clog2(ND + 1);

    rtb_state_e              state_r;
    rtb_state_e              state_s;
    logic [SR_W-1:0]         sr_r;
    logic [W-1:0]            q_r;
    logic [W-1:0]            qm_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [W-1:0]            out_value_r;
    logic [RADIX_BITS-1:0]   digit_s;
    logic [W-1:0]            q_step_s;
    logic [W-1:0]            qm_step_s;

    assign digit_s   = sr_r[SR_W-1 -: RADIX_BITS];
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign out_value = out_value_r;

    otf_digit_step #(
        .RADIX_BITS (RADIX_BITS),
        .L          (L),
        .W          (W)
    ) u_step (
        .q       (q_r),
        .qm      (qm_r),
        .d       (digit_s),
        .q_next  (q_step_s),
        .qm_next (qm_step_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_CONV;
                else          state_s = ST_IDLE;
            end
            ST_CONV: begin
                if (cnt_r == '0) state_s = ST_DONE;
                else             state_s = ST_CONV;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: latch word on accept, shift one digit per CONV cycle, publish on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r        <= '0;
            q_r         <= '0;
            qm_r        <= '1;
            cnt_r       <= '0;
            out_value_r <= '0;
        end else if (state_r == ST_IDLE && in_valid) begin
            sr_r  <= {in_cout, in_dout};
            q_r   <= '0;
            qm_r  <= '1;
            cnt_r <= CNT_W'(ND - 1);
        end else if (state_r == ST_CONV) begin
            sr_r  <= sr_r << RADIX_BITS;
            q_r   <= q_step_s;
            qm_r  <= qm_step_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == '0) begin
                out_value_r <= q_step_s;
            end else begin
                out_value_r <= out_value_r;
            end
        end else begin
            sr_r        <= sr_r;
            q_r         <= q_r;
            qm_r        <= qm_r;
            cnt_r       <= cnt_r;
            out_value_r <= out_value_r;
        end
    end

`ifdef RTB_DIGIT_CHECK_EN
    logic err_flag_r;
    logic out_err_r;
    logic illegal_s;

    assign illegal_s = (int'($signed(digit_s)) > digit_max(RADIX)) ||
                       (int'($signed(digit_s)) < digit_min(RADIX));
    assign out_err   = out_err_r;

    // Sticky illegal-digit flag for the word in flight; published with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_r <= 1'b0;
            out_err_r  <= 1'b0;
        end else if (state_r == ST_IDLE && in_valid) begin
            err_flag_r <= 1'b0;
        end else if (state_r == ST_CONV) begin
            err_flag_r <= err_flag_r | illegal_s;
            if (cnt_r == '0) begin
                out_err_r <= err_flag_r | illegal_s;
            end else begin
                out_err_r <= out_err_r;
            end
        end else begin
            err_flag_r <= err_flag_r;
            out_err_r  <= out_err_r;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_redundant_to_binary_converter.sv
// Directed bench for redundant_to_binary_converter at NO_OF_DIGITS=8, RADIX=2.
module tb_redundant_to_binary_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_dout;
    logic [1:0]  in_cout;
    logic        in_ready;
    logic        out_valid;
    logic        out_err;
    logic [9:0]  out_value;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RTB_DIGIT_CHECK_EN
    localparam logic EXP_ILLEGAL_ERR = 1'b1;
`else
    localparam logic EXP_ILLEGAL_ERR = 1'b0;
`endif

    redundant_to_binary_converter #(
        .NO_OF_DIGITS (8),
        .RADIX_BITS   (2),
        .RADIX        (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dout   (in_dout),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Send one word, check latency/value/err, optionally stall the consumer for hold cycles.
    task automatic run_word(input string tag, input logic [15:0] dout, input logic [1:0] cout,
                            input logic [9:0] exp_val, input logic exp_err,
                            input logic check_val, input int hold);
        int         lat;
        logic [9:0] prev;
        @(negedge clk);
        check_value({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_dout  = dout;
        in_cout  = cout;
        in_valid = 1'b1;
        prev     = out_value;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_value({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 4) check_value({tag, "_conv_hold"}, 32'(out_value), 32'(prev));
        end
        check_value({tag, "_latency"}, 32'(lat), 32'd9);
        if (check_val) check_value({tag, "_value"}, 32'(out_value), 32'(exp_val));
        check_value({tag, "_err"}, 32'(out_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_dout  = 16'h5555;
            in_cout  = 2'b00;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_value({tag, "_stall_value"}, 32'(out_value), 32'(exp_val));
            check_value({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check_value({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({tag, "_drained"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_value({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_dout   = 16'h0000;
        in_cout   = 2'b00;
        #12;
        check_value("rst_in_ready",  32'(in_ready),  32'd1);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_value", 32'(out_value), 32'd0);
        check_value("rst_out_err",   32'(out_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word("all_pos",   16'h5555, 2'b00, 10'd255,  1'b0, 1'b1, 0);
        run_word("all_neg",   16'hFFFF, 2'b11, 10'h201,  1'b0, 1'b1, 0);
        run_word("alt",       16'h7777, 2'b00, 10'd85,   1'b0, 1'b1, 0);
        run_word("alt_cout",  16'h7777, 2'b01, 10'd341,  1'b0, 1'b1, 0);
        run_word("stall",     16'hC000, 2'b01, 10'd128,  1'b0, 1'b1, 5);

        // Abort a conversion with reset on the 4th CONV edge.
        @(negedge clk);
        in_dout  = 16'h5555;
        in_cout  = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check_value("abort_out_valid", 32'(out_valid), 32'd0);
        check_value("abort_in_ready",  32'(in_ready),  32'd1);
        check_value("abort_out_value", 32'(out_value), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("post_abort", 16'h7777, 2'b01, 10'd341, 1'b0, 1'b1, 0);

        run_word("illegal",   16'h0002, 2'b00, 10'd0,   EXP_ILLEGAL_ERR, 1'b0, 0);
        run_word("legal_after", 16'h5555, 2'b00, 10'd255, 1'b0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
